// File: rtl/vote_pkg.sv
// Shared definitions for the voter and debounce stages.
package vote_pkg;

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } vote_state_e;

  localparam int unsigned HOLD_DEF     = 4;
  localparam int unsigned GLITCH_W_DEF = 8;

endpackage

// File: rtl/vote_debounce_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vote_debounce.sv
// Persistence filter behind the majority voter: accepts a new decision only after
// HOLD consecutive enabled disagreeing samples, with edge pulses and a glitch counter.
module vote_debounce
  import vote_pkg::*;
#(
  parameter int unsigned HOLD     = HOLD_DEF,
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned GLITCH_W = GLITCH_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                vote_in,
  input  logic                sample_en,
  input  logic                glitch_clr,
  output logic                out,
  output logic                rise,
  output logic                fall,
  output logic                pending,
  output logic [GLITCH_W-1:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD);

  vote_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_q, out_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             disagree;
  logic             abort;

  assign disagree = sample_en && (vote_in != out_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (disagree) begin
          if (HOLD == 1) begin
            out_d  = ~out_q;
            rise_d = ~out_q;
            fall_d = out_q;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        // A disabled cycle is a gap, not a break: state and count are held.
        if (sample_en) begin
          if (disagree) begin
            if (cnt_q + CNT_W'(1) == HOLD_CNT) begin
              out_d   = ~out_q;
              rise_d  = ~out_q;
              fall_d  = out_q;
              cnt_d   = '0;
              state_d = STABLE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            abort   = 1'b1;
            cnt_d   = '0;
            state_d = STABLE;
          end
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  sat_counter #(
    .W(GLITCH_W)
  ) u_glitch_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (glitch_clr),
    .inc  (abort),
    .cnt  (glitch_cnt)
  );

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign pending = (state_q == PENDING);

endmodule

// File: tb/tb_vote_debounce.sv
// Self-checking bench for vote_debounce: a HOLD=4 instance and a HOLD=1 instance,
// each compared cycle by cycle against a behavioural model via a scoreboard queue.
module tb_vote_debounce;

  typedef struct {
    logic out;
    logic rise;
    logic fall;
    logic pend;
    int   run;
    int   gl;
  } mstate_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vote_in = 1'b0, sample_en = 1'b0, glitch_clr = 1'b0;
  logic vote_in1 = 1'b0, sample_en1 = 1'b0, glitch_clr1 = 1'b0;
  logic out0, rise0, fall0, pend0, out1, rise1, fall1, pend1;
  logic [7:0] gcnt0, gcnt1;

  int errors = 0;
  int checks = 0;
  mstate_t m0, m1, mzero;
  logic [11:0] sb0[$];
  logic [11:0] sb1[$];
  logic [11:0] e;
  wire  [11:0] got0 = {out0, rise0, fall0, pend0, gcnt0};
  wire  [11:0] got1 = {out1, rise1, fall1, pend1, gcnt1};

  vote_debounce #(.HOLD(4), .CNT_W(3), .GLITCH_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .vote_in(vote_in), .sample_en(sample_en),
    .glitch_clr(glitch_clr), .out(out0), .rise(rise0), .fall(fall0),
    .pending(pend0), .glitch_cnt(gcnt0)
  );

  vote_debounce #(.HOLD(1), .CNT_W(3), .GLITCH_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .vote_in(vote_in1), .sample_en(sample_en1),
    .glitch_clr(glitch_clr1), .out(out1), .rise(rise1), .fall(fall1),
    .pending(pend1), .glitch_cnt(gcnt1)
  );

  always #5 clk = ~clk;

  function automatic mstate_t model_step(mstate_t s, int hold, logic en, logic v, logic clr);
    mstate_t n;
    logic ab;
    n = s;
    ab = 1'b0;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (en) begin
      if (v != s.out) begin
        n.run = s.run + 1;
        if (n.run >= hold) begin
          n.out  = ~s.out;
          n.rise = ~s.out;
          n.fall = s.out;
          n.run  = 0;
          n.pend = 1'b0;
        end else begin
          n.pend = 1'b1;
        end
      end else begin
        ab     = s.pend;
        n.run  = 0;
        n.pend = 1'b0;
      end
    end
    if (clr) n.gl = 0;
    else if (ab && s.gl < 255) n.gl = s.gl + 1;
    return n;
  endfunction

  function automatic logic [11:0] pack_m(mstate_t s);
    logic [7:0] g;
    g = s.gl[7:0];
    return {s.out, s.rise, s.fall, s.pend, g};
  endfunction

  task automatic drive(input logic en, input logic v, input logic clr);
    @(negedge clk);
    sample_en = en; vote_in = v; glitch_clr = clr;
    sample_en1 = 1'b0; glitch_clr1 = 1'b0;
    m0 = model_step(m0, 4, en, v, clr);
    sb0.push_back(pack_m(m0));
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic en, input logic v);
    @(negedge clk);
    sample_en1 = en; vote_in1 = v; glitch_clr1 = 1'b0;
    sample_en = 1'b0; glitch_clr = 1'b0;
    m1 = model_step(m1, 1, en, v, 1'b0);
    sb1.push_back(pack_m(m1));
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if (got0 !== 12'h000 || got1 !== 12'h000) begin
      errors++;
      $display("FAIL reset got0=%h got1=%h exp=000", got0, got1);
    end
    m0 = mzero; m1 = mzero;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_glitch();
    for (int r = 0; r < 301; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, (k < 3) ? 1'b1 : 1'b0, 1'b0);
        e = sb0.pop_front();
        checks++;
        if (got0 !== e) begin
          errors++;
          $display("FAIL glitch r%0d k%0d got=%h exp=%h", r, k, got0, e);
        end
      end
    end
    checks++;
    if (gcnt0 !== 8'd255) begin
      errors++;
      $display("FAIL glitch_sat got=%0d exp=255", gcnt0);
    end
  endtask

  task automatic test_clear_abort();
    drive(1'b0, 1'b0, 1'b1);
    e = sb0.pop_front();
    checks++;
    if (got0 !== e) begin
      errors++;
      $display("FAIL clear got=%h exp=%h", got0, e);
    end
    // five glitches to reach 5, then three disagreeing samples and an abort with clear
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, ((i % 4) < 3) ? 1'b1 : 1'b0, (i == 23) ? 1'b1 : 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL clear_abort i%0d got=%h exp=%h", i, got0, e);
      end
      if (i == 19) begin
        checks++;
        if (gcnt0 !== 8'd5) begin
          errors++;
          $display("FAIL clear_abort_pre got=%0d exp=5", gcnt0);
        end
      end
    end
    checks++;
    if (gcnt0 !== 8'd0) begin
      errors++;
      $display("FAIL clear_wins got=%0d exp=0", gcnt0);
    end
  endtask

  task automatic test_clean();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL clean i%0d got=%h exp=%h", i, got0, e);
      end
      if (i == 3) begin
        checks++;
        if ({out0, rise0, fall0} !== 3'b110) begin
          errors++;
          $display("FAIL clean_accept got=%b exp=110", {out0, rise0, fall0});
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, ((i / 4) == 1) ? 1'b1 : 1'b0, 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL back_to_back i%0d got=%h exp=%h", i, got0, e);
      end
    end
  endtask

  task automatic test_gaps();
    logic [5:0] en_pat;
    en_pat = 6'b110101;
    for (int i = 0; i < 6; i++) begin
      drive(en_pat[i], 1'b1, 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL gaps i%0d got=%h exp=%h", i, got0, e);
      end
      if (i < 5) begin
        checks++;
        if (pend0 !== 1'b1 || out0 !== 1'b0) begin
          errors++;
          $display("FAIL gaps_hold i%0d got=%b%b exp=10", i, pend0, out0);
        end
      end
    end
    checks++;
    if (out0 !== 1'b1) begin
      errors++;
      $display("FAIL gaps_accept got=%b exp=1", out0);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ~m0.out, 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL reset_mid_pre i%0d got=%h exp=%h", i, got0, e);
      end
    end
    #2;
    sample_en = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++;
    if (got0 !== 12'h000 || got1 !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid got0=%h got1=%h exp=000", got0, got1);
    end
    m0 = mzero; m1 = mzero;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      e = sb0.pop_front();
      checks++;
      if (got0 !== e) begin
        errors++;
        $display("FAIL reset_mid_post i%0d got=%h exp=%h", i, got0, e);
      end
      checks++;
      if (out0 !== ((i == 3) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL reset_mid_out i%0d got=%b exp=%b", i, out0, (i == 3));
      end
    end
  endtask

  task automatic test_hold1();
    logic [7:0] en_pat, v_pat;
    en_pat = 8'b11111011;
    v_pat  = 8'b01010010;
    for (int i = 0; i < 8; i++) begin
      drive1(en_pat[i], v_pat[i]);
      e = sb1.pop_front();
      checks++;
      if (got1 !== e) begin
        errors++;
        $display("FAIL hold1 i%0d got=%h exp=%h", i, got1, e);
      end
      checks++;
      if (pend1 !== 1'b0) begin
        errors++;
        $display("FAIL hold1_pending i%0d got=%b exp=0", i, pend1);
      end
    end
  endtask

  initial begin
    mzero = '{out: 1'b0, rise: 1'b0, fall: 1'b0, pend: 1'b0, run: 0, gl: 0};
    m0 = mzero;
    m1 = mzero;
    test_reset();
    test_glitch();
    test_clear_abort();
    test_clean();
    test_back_to_back();
    test_gaps();
    test_reset_mid();
    test_hold1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
